// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle between the miss controller, the CPU core, the cache and main memory.
// master = controller side, slave = surrounding core/cache/memory side.
interface cache_fill_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;

    logic [15:0] cache_addr;
    logic        cache_w_rd;
    logic [7:0]  cache_wdata;
    logic        cache_data_oe;
    logic [7:0]  cache_rdata;
    logic        cache_hit;

    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err,
        output cache_addr, cache_w_rd, cache_wdata, cache_data_oe,
        input  cache_rdata, cache_hit,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err,
        input  cache_addr, cache_w_rd, cache_wdata, cache_data_oe,
        output cache_rdata, cache_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss-handling controller: serialises CPU byte requests, fills on read miss,
// write-through with allocate on write, saturating hit/miss counters.
module cache_fill_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk_1,
    input  logic                 rst,
    cache_fill_ctrl_if.master    bus,
    output logic [15:0]          hit_cnt,
    output logic [15:0]          miss_cnt
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, CHECK, MEM_RD, FILL, WR_CACHE, MEM_WR, DONE
    } state_t;

    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      state;
    state_t      state_nx;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  data_q;
    logic        err_q;
    logic [7:0]  tmo_q;
    logic [15:0] hit_q;
    logic [15:0] miss_q;
    logic        in_mem;
    logic        tmo_fire;

    assign in_mem   = (state == MEM_RD) || (state == MEM_WR);
    // an ack arriving on the last allowed cycle still counts as success
    assign tmo_fire = (tmo_q == TMO_LAST) && !bus.mem_ack;

    assign bus.cache_addr = addr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_rdata  = data_q;
    assign bus.cpu_err    = err_q;
    assign hit_cnt        = hit_q;
    assign miss_cnt       = miss_q;

    always_comb begin
        state_nx          = state;
        bus.cache_w_rd    = 1'b0;
        bus.cache_data_oe = 1'b0;
        bus.cache_wdata   = wdata_q;
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.cpu_ready     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cpu_req)
                    state_nx = bus.cpu_we ? WR_CACHE : LOOKUP;
            end
            LOOKUP: state_nx = CHECK;
            CHECK:  state_nx = bus.cache_hit ? DONE : MEM_RD;
            MEM_RD: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack)
                    state_nx = FILL;
                else if (tmo_fire)
                    state_nx = DONE;
            end
            FILL: begin
                bus.cache_w_rd    = 1'b1;
                bus.cache_data_oe = 1'b1;
                bus.cache_wdata   = data_q;
                state_nx          = DONE;
            end
            WR_CACHE: begin
                bus.cache_w_rd    = 1'b1;
                bus.cache_data_oe = 1'b1;
                state_nx          = MEM_WR;
            end
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                if (bus.mem_ack || tmo_fire)
                    state_nx = DONE;
            end
            DONE: begin
                bus.cpu_ready = 1'b1;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.cpu_req) begin
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
                data_q  <= '0;
                err_q   <= 1'b0;
            end
            if (state == CHECK) begin
                if (bus.cache_hit) begin
                    data_q <= bus.cache_rdata;
                    if (hit_q != CNT_MAX)
                        hit_q <= hit_q + 16'd1;
                end else if (miss_q != CNT_MAX) begin
                    miss_q <= miss_q + 16'd1;
                end
            end
            if (state == MEM_RD && bus.mem_ack)
                data_q <= bus.mem_rdata;
            if (in_mem && tmo_fire)
                err_q <= 1'b1;
            if (state_nx != state &&
                (state_nx == MEM_RD || state_nx == MEM_WR))
                tmo_q <= '0;
            else if (in_mem)
                tmo_q <= tmo_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: emulated cache and memory, plus a
// transaction-level reference of cache contents, latency and counters.
module tb_cache_fill_ctrl;

    localparam int T = 4;

    logic        clk_1 = 1'b0;
    logic        rst;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    always #5 clk_1 = ~clk_1;

    cache_fill_ctrl_if bus();

    cache_fill_ctrl #(.TIMEOUT(T)) dut (
        .clk_1    (clk_1),
        .rst      (rst),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    int checks = 0;
    int errors = 0;

    // emulated 128-byte direct-mapped cache
    logic       c_valid [128];
    logic [8:0] c_tag   [128];
    logic [7:0] c_data  [128];
    logic [7:0] init_data [128];
    logic       preset;
    int         fill_cnt = 0;
    int         oe_bad = 0;
    wire  [6:0] c_idx = bus.cache_addr[6:0];

    assign bus.cache_hit   = c_valid[c_idx] && (c_tag[c_idx] == bus.cache_addr[15:7]);
    assign bus.cache_rdata = c_data[c_idx];

    always @(posedge clk_1) begin
        if (preset) begin
            for (int i = 0; i < 128; i++) begin
                c_valid[i] <= 1'b1;
                c_tag[i]   <= 9'd0;
                c_data[i]  <= init_data[i];
            end
        end else if (bus.cache_w_rd) begin
            c_valid[c_idx] <= 1'b1;
            c_tag[c_idx]   <= bus.cache_addr[15:7];
            c_data[c_idx]  <= bus.cache_wdata;
            fill_cnt       <= fill_cnt + 1;
        end
        if (bus.cache_data_oe !== bus.cache_w_rd)
            oe_bad <= oe_bad + 1;
    end

    // emulated memory: acks in the ack_k-th cycle of mem_req (0 = never)
    int          ack_k = 0;
    logic [7:0]  mbyte = 8'h00;
    int          mcnt = 0;
    int          mw_cnt = 0;
    logic [15:0] mw_addr = 16'h0;
    logic [7:0]  mw_data = 8'h0;

    always @(negedge clk_1) begin
        if (bus.mem_req === 1'b1) begin
            mcnt = mcnt + 1;
            bus.mem_ack   = (mcnt == ack_k);
            bus.mem_rdata = mbyte;
            if (bus.mem_ack && bus.mem_we) begin
                mw_cnt  = mw_cnt + 1;
                mw_addr = bus.mem_addr;
                mw_data = bus.mem_wdata;
            end
        end else begin
            mcnt          = 0;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'h00;
        end
    end

    // reference model state
    logic       r_valid [128];
    logic [8:0] r_tag   [128];
    logic [7:0] r_data  [128];
    logic [15:0] r_hits;
    logic [15:0] r_miss;

    task automatic model_req(input logic we, input logic [15:0] a,
                             input logic [7:0] wd, input int k,
                             input logic [7:0] mb, output int lat,
                             output logic [7:0] rd, output logic e,
                             output int fills);
        int ix;
        logic [8:0] tg;
        bit acked;
        ix = int'(a[6:0]);
        tg = a[15:7];
        acked = (k >= 1) && (k <= T);
        if (!we) begin
            if (r_valid[ix] && r_tag[ix] == tg) begin
                lat = 3; rd = r_data[ix]; e = 1'b0; fills = 0;
                if (r_hits != 16'hFFFF) r_hits = r_hits + 16'd1;
            end else begin
                if (r_miss != 16'hFFFF) r_miss = r_miss + 16'd1;
                if (acked) begin
                    lat = 4 + k; rd = mb; e = 1'b0; fills = 1;
                    r_valid[ix] = 1'b1; r_tag[ix] = tg; r_data[ix] = mb;
                end else begin
                    lat = 3 + T; rd = 8'h00; e = 1'b1; fills = 0;
                end
            end
        end else begin
            r_valid[ix] = 1'b1; r_tag[ix] = tg; r_data[ix] = wd;
            fills = 1; rd = 8'h00;
            if (acked) begin lat = 2 + k; e = 1'b0; end
            else begin lat = 2 + T; e = 1'b1; end
        end
    endtask

    // drives one request; lat stays 0 when no completion pulse occurs
    task automatic run_req(input logic we, input logic [15:0] a,
                           input logic [7:0] wd, input int k,
                           input logic [7:0] mb, output int lat,
                           output logic [7:0] rd, output logic e,
                           output int fills);
        int f0;
        f0 = fill_cnt;
        ack_k = k;
        mbyte = mb;
        lat = 0; rd = 8'h00; e = 1'b0;
        @(negedge clk_1);
        bus.cpu_req = 1'b1; bus.cpu_we = we;
        bus.cpu_addr = a; bus.cpu_wdata = wd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_1);
            bus.cpu_we    = 1'($urandom);
            bus.cpu_addr  = 16'($urandom);
            bus.cpu_wdata = 8'($urandom);
            if (bus.cpu_ready === 1'b1) begin
                lat = c; rd = bus.cpu_rdata; e = bus.cpu_err;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        fills = fill_cnt - f0;
    endtask

    task automatic test_reset();
        @(negedge clk_1);
        checks++;
        if ({bus.cpu_ready, bus.cpu_err, bus.cache_w_rd, bus.cache_data_oe,
             bus.mem_req, bus.mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {bus.cpu_ready, bus.cpu_err, bus.cache_w_rd,
                      bus.cache_data_oe, bus.mem_req, bus.mem_we});
        end
        checks++;
        if ({bus.cpu_rdata, bus.cache_addr, bus.cache_wdata, bus.mem_addr,
             bus.mem_wdata} !== 56'h0) begin
            errors++;
            $display("FAIL reset_bus got %h want 0",
                     {bus.cpu_rdata, bus.cache_addr, bus.cache_wdata,
                      bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if ({hit_cnt, miss_cnt} !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 0", {hit_cnt, miss_cnt});
        end
    endtask

    task automatic test_first_hit();
        int el, ol, ef, of;
        logic [7:0] er, orr;
        logic ee, oe;
        model_req(1'b0, 16'h0000, 8'h00, 0, 8'h00, el, er, ee, ef);
        run_req(1'b0, 16'h0000, 8'h00, 0, 8'h00, ol, orr, oe, of);
        checks++;
        if (ol !== 3) begin errors++; $display("FAIL hit_lat got %0d want 3", ol); end
        checks++;
        if (orr !== 8'h69) begin errors++; $display("FAIL hit_rdata got %h want 69", orr); end
        checks++;
        if (hit_cnt !== 16'd1) begin errors++; $display("FAIL hit_cnt1 got %0d want 1", hit_cnt); end
    endtask

    task automatic test_read_miss();
        int el, ol, ef, of;
        logic [7:0] er, orr;
        logic ee, oe;
        model_req(1'b0, 16'h8005, 8'h00, 2, 8'h5A, el, er, ee, ef);
        run_req(1'b0, 16'h8005, 8'h00, 2, 8'h5A, ol, orr, oe, of);
        checks++;
        if (ol !== 6) begin errors++; $display("FAIL miss_lat got %0d want 6", ol); end
        checks++;
        if (orr !== 8'h5A || oe !== 1'b0) begin
            errors++; $display("FAIL miss_rdata got %h/%b want 5a/0", orr, oe);
        end
        checks++;
        if (of !== 1 || c_data[5] !== 8'h5A || c_tag[5] !== 9'h100) begin
            errors++;
            $display("FAIL miss_fill got n=%0d d=%h t=%h want 1/5a/100",
                     of, c_data[5], c_tag[5]);
        end
        model_req(1'b0, 16'h8005, 8'h00, 0, 8'h00, el, er, ee, ef);
        run_req(1'b0, 16'h8005, 8'h00, 0, 8'h00, ol, orr, oe, of);
        checks++;
        if (ol !== 3 || orr !== 8'h5A) begin
            errors++; $display("FAIL rehit got %0d/%h want 3/5a", ol, orr);
        end
        checks++;
        if (miss_cnt !== r_miss || hit_cnt !== r_hits) begin
            errors++;
            $display("FAIL miss_cnts got %0d/%0d want %0d/%0d",
                     hit_cnt, miss_cnt, r_hits, r_miss);
        end
    endtask

    task automatic test_write();
        int el, ol, ef, of, m0, b0;
        logic [7:0] er, orr;
        logic ee, oe;
        m0 = mw_cnt;
        b0 = oe_bad;
        model_req(1'b1, 16'h1234, 8'hC3, 1, 8'h00, el, er, ee, ef);
        run_req(1'b1, 16'h1234, 8'hC3, 1, 8'h00, ol, orr, oe, of);
        checks++;
        if (ol !== 3 || oe !== 1'b0 || orr !== 8'h00) begin
            errors++; $display("FAIL wr_done got %0d/%b/%h want 3/0/00", ol, oe, orr);
        end
        checks++;
        if (mw_cnt - m0 !== 1 || mw_addr !== 16'h1234 || mw_data !== 8'hC3) begin
            errors++;
            $display("FAIL wr_mem got n=%0d %h=%h want 1 1234=c3",
                     mw_cnt - m0, mw_addr, mw_data);
        end
        checks++;
        if (of !== 1 || oe_bad !== b0 || c_data[7'h34] !== 8'hC3) begin
            errors++;
            $display("FAIL wr_cache got n=%0d oe_bad=%0d d=%h want 1/%0d/c3",
                     of, oe_bad, c_data[7'h34], b0);
        end
        model_req(1'b0, 16'h1234, 8'h00, 0, 8'h00, el, er, ee, ef);
        run_req(1'b0, 16'h1234, 8'h00, 0, 8'h00, ol, orr, oe, of);
        checks++;
        if (ol !== 3 || orr !== 8'hC3) begin
            errors++; $display("FAIL wr_readback got %0d/%h want 3/c3", ol, orr);
        end
    endtask

    task automatic test_timeout();
        int el, ol, ef, of, m0;
        logic [7:0] er, orr;
        logic ee, oe;
        model_req(1'b0, 16'h4321, 8'h00, 0, 8'h00, el, er, ee, ef);
        run_req(1'b0, 16'h4321, 8'h00, 0, 8'h00, ol, orr, oe, of);
        checks++;
        if (ol !== 3 + T || oe !== 1'b1 || orr !== 8'h00 || of !== 0) begin
            errors++;
            $display("FAIL rd_tmo got %0d/%b/%h/%0d want %0d/1/00/0",
                     ol, oe, orr, of, 3 + T);
        end
        model_req(1'b0, 16'h4321, 8'h00, 3, 8'h3C, el, er, ee, ef);
        run_req(1'b0, 16'h4321, 8'h00, 3, 8'h3C, ol, orr, oe, of);
        checks++;
        if (ol !== 7 || oe !== 1'b0 || orr !== 8'h3C || miss_cnt !== r_miss) begin
            errors++;
            $display("FAIL tmo_remiss got %0d/%b/%h/%0d want 7/0/3c/%0d",
                     ol, oe, orr, miss_cnt, r_miss);
        end
        model_req(1'b0, 16'h2222, 8'h00, T, 8'hA5, el, er, ee, ef);
        run_req(1'b0, 16'h2222, 8'h00, T, 8'hA5, ol, orr, oe, of);
        checks++;
        if (ol !== 4 + T || oe !== 1'b0 || orr !== 8'hA5) begin
            errors++;
            $display("FAIL ack_at_limit got %0d/%b/%h want %0d/0/a5",
                     ol, oe, orr, 4 + T);
        end
        m0 = mw_cnt;
        model_req(1'b1, 16'h0777, 8'h11, 0, 8'h00, el, er, ee, ef);
        run_req(1'b1, 16'h0777, 8'h11, 0, 8'h00, ol, orr, oe, of);
        checks++;
        if (ol !== 2 + T || oe !== 1'b1 || of !== 1 ||
            c_data[7'h77] !== 8'h11 || mw_cnt !== m0) begin
            errors++;
            $display("FAIL wr_tmo got %0d/%b/%0d/%h want %0d/1/1/11",
                     ol, oe, of, c_data[7'h77], 2 + T);
        end
    endtask

    task automatic test_reset_mid();
        int el, ol, ef, of, f0, pulses;
        logic [7:0] er, orr;
        logic ee, oe;
        bit seen;
        ack_k = 0;
        seen = 0;
        f0 = fill_cnt;
        @(negedge clk_1);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h6000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_1);
            bus.cpu_req = 1'b0;
            if (bus.mem_req === 1'b1) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rm_memreq got 0 want 1"); end
        rst = 1'b1;
        @(negedge clk_1);
        rst = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b0 ||
            hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rm_state got req=%b rdy=%b h=%0d m=%0d want 0/0/0/0",
                     bus.mem_req, bus.cpu_ready, hit_cnt, miss_cnt);
        end
        r_hits = 16'h0;
        r_miss = 16'h0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_1);
            if (bus.cpu_ready === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || fill_cnt !== f0) begin
            errors++;
            $display("FAIL rm_quiet got rdy=%0d fills=%0d want 0/0",
                     pulses, fill_cnt - f0);
        end
        model_req(1'b0, 16'h6000, 8'h00, 1, 8'h77, el, er, ee, ef);
        run_req(1'b0, 16'h6000, 8'h00, 1, 8'h77, ol, orr, oe, of);
        checks++;
        if (ol !== 5 || orr !== 8'h77 || miss_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rm_fresh got %0d/%h/%0d want 5/77/1", ol, orr, miss_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int el, ol, ef, of;
        logic [7:0] er, orr;
        logic ee, oe;
        logic [15:0] a;
        a = {r_tag[0], 7'd0};
        for (int i = 0; i < 3; i++) begin
            model_req(1'b0, a, 8'h00, 0, 8'h00, el, er, ee, ef);
            run_req(1'b0, a, 8'h00, 0, 8'h00, ol, orr, oe, of);
            checks++;
            if (ol !== 3 || orr !== er) begin
                errors++;
                $display("FAIL b2b_%0d got %0d/%h want 3/%h", i, ol, orr, er);
            end
        end
        @(negedge clk_1);
        checks++;
        if (bus.cpu_ready !== 1'b0) begin
            errors++; $display("FAIL ready_pulse got 1 want 0");
        end
    endtask

    task automatic test_saturate();
        int el, ol, ef, of;
        logic [7:0] er, orr;
        logic ee, oe;
        logic [15:0] a;
        @(negedge clk_1);
        force dut.hit_q = 16'hFFFF;
        @(negedge clk_1);
        release dut.hit_q;
        r_hits = 16'hFFFF;
        a = {r_tag[3], 7'd3};
        model_req(1'b0, a, 8'h00, 0, 8'h00, el, er, ee, ef);
        run_req(1'b0, a, 8'h00, 0, 8'h00, ol, orr, oe, of);
        checks++;
        if (hit_cnt !== 16'hFFFF || ol !== 3) begin
            errors++;
            $display("FAIL hit_sat got %h/%0d want ffff/3", hit_cnt, ol);
        end
    endtask

    task automatic test_random();
        int el, ol, ef, of, k, ix;
        logic [7:0] er, orr, wd, mb;
        logic ee, oe, we;
        logic [15:0] a;
        logic [8:0] tags [4];
        tags[0] = 9'h000; tags[1] = 9'h001; tags[2] = 9'h002; tags[3] = 9'h100;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 2) == 0);
            a  = {tags[$urandom_range(0, 3)], 7'($urandom_range(0, 7))};
            wd = 8'($urandom);
            mb = 8'($urandom);
            k  = $urandom_range(0, T + 1);
            ix = int'(a[6:0]);
            model_req(we, a, wd, k, mb, el, er, ee, ef);
            run_req(we, a, wd, k, mb, ol, orr, oe, of);
            checks++;
            if (ol !== el || orr !== er || oe !== ee || of !== ef) begin
                errors++;
                $display("FAIL rnd_%0d got %0d/%h/%b/%0d want %0d/%h/%b/%0d",
                         i, ol, orr, oe, of, el, er, ee, ef);
            end
            checks++;
            if (hit_cnt !== r_hits || miss_cnt !== r_miss ||
                {c_valid[ix], c_tag[ix], c_data[ix]} !==
                {r_valid[ix], r_tag[ix], r_data[ix]}) begin
                errors++;
                $display("FAIL rnd_state_%0d got %0d/%0d/%h want %0d/%0d/%h",
                         i, hit_cnt, miss_cnt, {c_tag[ix], c_data[ix]},
                         r_hits, r_miss, {r_tag[ix], r_data[ix]});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
        for (int i = 0; i < 128; i++) begin
            init_data[i] = 8'($urandom);
        end
        init_data[0] = 8'h69;
        for (int i = 0; i < 128; i++) begin
            r_valid[i] = 1'b1; r_tag[i] = 9'd0; r_data[i] = init_data[i];
        end
        r_hits = 16'h0;
        r_miss = 16'h0;
        rst = 1'b1;
        preset = 1'b1;
        repeat (3) @(posedge clk_1);
        @(negedge clk_1);
        rst = 1'b0;
        preset = 1'b0;
        test_reset();
        test_first_hit();
        test_read_miss();
        test_write();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
